// File: rtl/watch_time_counter.sv
// watch_time_counter
// Turns rising edges of the slow divided tick into one-second advances of a
// 24-hour BCD time of day (HH:MM:SS), with a load handshake for setting time.
//
// Ports:
//   clk_27Mhz                         system clock, all logic on its rising edge
//   rst                               synchronous active-high reset
//   tick_in                           divided slow tick, treated as async data
//   set_valid                         load request for set_hours/minutes/seconds
//   set_hours/set_minutes/set_seconds BCD values to load
//   set_ack / set_err                 one-cycle load accepted / rejected pulses
//   hours_bcd/minutes_bcd/seconds_bcd current time, BCD
//   sec_pulse/min_pulse/hour_pulse/day_pulse  one-cycle carry pulses
module watch_time_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOUR_MAX    = 23
) (
  input  logic       clk_27Mhz,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_valid,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_minutes,
  input  logic [7:0] set_seconds,
  output logic       set_ack,
  output logic       set_err,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       day_pulse
);

  localparam logic [7:0] HourMaxBcd = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

  // BCD increment of a two-digit value; callers handle the wrap point.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two BCD digits no greater than 59.
  function automatic logic bcd_59_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_armed;
  logic [7:0]             r_hours, r_minutes, r_seconds;
  logic                   r_sec_p, r_min_p, r_hour_p, r_day_p;
  logic                   r_ack, r_err;

  logic                   w_synced, w_strobe, w_set_ok;
  logic [7:0]             w_hours, w_minutes, w_seconds;
  logic                   w_sec_p, w_min_p, w_hour_p, w_day_p;

  assign w_synced = r_sync[SYNC_STAGES-1];
  // r_armed blocks the spurious edge seen when tick_in is already high at
  // reset release: advancing needs a genuine low sample first.
  assign w_strobe = w_synced & ~r_prev & r_armed;

  assign w_set_ok = bcd_59_ok(set_seconds) && bcd_59_ok(set_minutes) &&
                    (set_hours[3:0] <= 4'd9) && (set_hours[7:4] <= 4'd9) &&
                    (set_hours <= HourMaxBcd);

  always_comb begin
    w_hours   = r_hours;
    w_minutes = r_minutes;
    w_seconds = r_seconds;
    w_sec_p   = 1'b0;
    w_min_p   = 1'b0;
    w_hour_p  = 1'b0;
    w_day_p   = 1'b0;
    if (set_valid && w_set_ok) begin
      // A valid load wins over a coincident advance, which is dropped.
      w_hours   = set_hours;
      w_minutes = set_minutes;
      w_seconds = set_seconds;
    end else if (w_strobe) begin
      w_sec_p = 1'b1;
      if (r_seconds == 8'h59) begin
        w_seconds = 8'h00;
        w_min_p   = 1'b1;
        if (r_minutes == 8'h59) begin
          w_minutes = 8'h00;
          w_hour_p  = 1'b1;
          if (r_hours == HourMaxBcd) begin
            w_hours = 8'h00;
            w_day_p = 1'b1;
          end else begin
            w_hours = bcd_inc(r_hours);
          end
        end else begin
          w_minutes = bcd_inc(r_minutes);
        end
      end else begin
        w_seconds = bcd_inc(r_seconds);
      end
    end
  end

  always_ff @(posedge clk_27Mhz) begin
    if (rst) begin
      r_sync    <= '0;
      r_fill    <= '0;
      r_prev    <= 1'b0;
      r_armed   <= 1'b0;
      r_hours   <= 8'h00;
      r_minutes <= 8'h00;
      r_seconds <= 8'h00;
      r_sec_p   <= 1'b0;
      r_min_p   <= 1'b0;
      r_hour_p  <= 1'b0;
      r_day_p   <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], tick_in};
      // r_fill marks when the synchroniser output is a real post-reset sample.
      r_fill    <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev    <= w_synced;
      if (r_fill[SYNC_STAGES-1] && !w_synced) r_armed <= 1'b1;
      r_hours   <= w_hours;
      r_minutes <= w_minutes;
      r_seconds <= w_seconds;
      r_sec_p   <= w_sec_p;
      r_min_p   <= w_min_p;
      r_hour_p  <= w_hour_p;
      r_day_p   <= w_day_p;
      r_ack     <= set_valid & w_set_ok;
      r_err     <= set_valid & ~w_set_ok;
    end
  end

  assign hours_bcd   = r_hours;
  assign minutes_bcd = r_minutes;
  assign seconds_bcd = r_seconds;
  assign sec_pulse   = r_sec_p;
  assign min_pulse   = r_min_p;
  assign hour_pulse  = r_hour_p;
  assign day_pulse   = r_day_p;
  assign set_ack     = r_ack;
  assign set_err     = r_err;

endmodule
